// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART transmitter:
//               frame state encoding, character-length encodings and the
//               parity constants and helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Transmitter frame states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_BREAK  = 3'd6
  } uart_state_e;

  // data_bit_num encodings
  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  // parity_type encodings
  localparam logic EVEN = 1'b1;
  localparam logic ODD  = 1'b0;

  // Number of data bits for a data_bit_num encoding
  function automatic logic [3:0] data_bits(input logic [1:0] enc);
    logic [3:0] n;
    n = 4'd8;
    unique case (enc)
      DBITS_5: n = 4'd5;
      DBITS_6: n = 4'd6;
      DBITS_7: n = 4'd7;
      DBITS_8: n = 4'd8;
    endcase
    return n;
  endfunction

  // Parity over the low n bits of data; even = XOR, odd = its inverse
  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic [3:0] n,
                                       input logic       ptype);
    logic x;
    logic p;
    x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(n)) x ^= data[i];
    end
    p = x;
    unique case (ptype)
      EVEN: p = x;
      ODD:  p = ~x;
    endcase
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO without bypass. Read data is presented
//               combinationally from the head entry.
// Ports       : clk, reset_n (async, active low)
//               push/wdata  - write request and data (ignored when full)
//               pop/rdata   - read request (ignored when empty), head data
//               full, empty, level - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int              AW     = $clog2(DEPTH);
  localparam logic [AW:0]     C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      // Simultaneous push and pop leaves the level unchanged
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  assign rdata = r_mem[r_rptr];
  assign full  = (r_level == C_FULL);
  assign empty = (r_level == '0);
  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter with write FIFO, programmable baud divisor
//               and break generation. Frames: start, 5-8 data bits LSB first,
//               optional parity, 1 or 2 stop bits, back-to-back when queued.
// Ports       : clk, reset_n (async, active low)
//               baud_div, data_bit_num, stop_bit_num, parity_en, parity_type
//                 - frame configuration, latched at frame start
//               tx_en, break_req - frame start permission / break request
//               wr_valid, wr_data, wr_ready - character write port
//               fifo_level - stored characters
//               tx (registered line), busy, tx_done (frame-end pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DIV_W-1:0]       baud_div,
  input  logic [1:0]             data_bit_num,
  input  logic                   stop_bit_num,
  input  logic                   parity_en,
  input  logic                   parity_type,
  input  logic                   tx_en,
  input  logic                   break_req,
  input  logic                   wr_valid,
  input  logic [7:0]             wr_data,
  output logic                   wr_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   tx,
  output logic                   busy,
  output logic                   tx_done
);

  uart_state_e      r_state;
  uart_state_e      w_state_nx;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [2:0]       r_nlast;
  logic [7:0]       r_shift;
  logic             r_stop2;
  logic             r_pen;
  logic             r_par;
  logic             r_brk_rel;
  logic             r_tx;
  logic             r_done;

  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_rdata;
  logic             w_push;
  logic             w_pop;
  logic             w_bit_end;
  logic             w_cnt_clr;
  logic             w_shift;
  logic             w_bit_inc;
  logic             w_brk_rel;
  logic             w_frame_end;
  logic             w_done;
  logic             w_line;

  assign w_push   = wr_valid && !w_full;
  assign wr_ready = !w_full;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .wdata   (wr_data),
    .pop     (w_pop),
    .rdata   (w_rdata),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  assign w_bit_end = (r_cnt == r_div);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nx;
  end

  // Next-state and control strobes
  always_comb begin
    w_state_nx  = r_state;
    w_pop       = 1'b0;
    w_cnt_clr   = 1'b0;
    w_shift     = 1'b0;
    w_bit_inc   = 1'b0;
    w_brk_rel   = 1'b0;
    w_frame_end = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (break_req) begin
          w_state_nx = ST_BREAK;
          w_cnt_clr  = 1'b1;
        end else if (tx_en && !w_empty) begin
          w_pop      = 1'b1;
          w_state_nx = ST_START;
          w_cnt_clr  = 1'b1;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nx = ST_DATA;
          w_cnt_clr  = 1'b1;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift   = 1'b1;
          w_cnt_clr = 1'b1;
          if (r_bit == r_nlast) w_state_nx = r_pen ? ST_PARITY : ST_STOP1;
          else                  w_bit_inc  = 1'b1;
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nx = ST_STOP1;
          w_cnt_clr  = 1'b1;
        end
      end
      ST_STOP1: begin
        if (w_bit_end) begin
          if (r_stop2) begin
            w_state_nx = ST_STOP2;
            w_cnt_clr  = 1'b1;
          end else begin
            w_frame_end = 1'b1;
          end
        end
      end
      ST_STOP2: begin
        if (w_bit_end) w_frame_end = 1'b1;
      end
      ST_BREAK: begin
        // Counter is held at zero while the line is forced low; once the
        // request drops, one bit period of mark precedes the return to IDLE.
        if (!r_brk_rel) begin
          w_cnt_clr = 1'b1;
          if (!break_req) w_brk_rel = 1'b1;
        end else if (w_bit_end) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase

    // Frame end chains straight into the next START when data is queued
    if (w_frame_end) begin
      w_done    = 1'b1;
      w_cnt_clr = 1'b1;
      if (tx_en && !break_req && !w_empty) begin
        w_pop      = 1'b1;
        w_state_nx = ST_START;
      end else begin
        w_state_nx = ST_IDLE;
      end
    end
  end

  // Line level for the current state; registered into tx below, so the pad
  // trails the state by one clock.
  always_comb begin
    w_line = 1'b1;
    case (r_state)
      ST_START:  w_line = 1'b0;
      ST_DATA:   w_line = r_shift[0];
      ST_PARITY: w_line = r_par;
      ST_BREAK:  w_line = r_brk_rel;
      default:   w_line = 1'b1;
    endcase
  end

  // Datapath: frame registers, counters, shifter and outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_div     <= '0;
      r_bit     <= '0;
      r_nlast   <= '0;
      r_shift   <= '0;
      r_stop2   <= 1'b0;
      r_pen     <= 1'b0;
      r_par     <= 1'b0;
      r_brk_rel <= 1'b0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      if (w_cnt_clr)               r_cnt <= '0;
      else if (r_state != ST_IDLE) r_cnt <= r_cnt + 1'b1;

      if (w_pop) begin
        r_div   <= baud_div;
        r_nlast <= 3'(data_bits(data_bit_num) - 4'd1);
        r_stop2 <= stop_bit_num;
        r_pen   <= parity_en;
        r_par   <= calc_parity(w_rdata, data_bits(data_bit_num), parity_type);
        r_shift <= w_rdata;
        r_bit   <= '0;
      end else begin
        if (w_shift)   r_shift <= {1'b0, r_shift[7:1]};
        if (w_bit_inc) r_bit   <= r_bit + 1'b1;
        if (w_brk_rel) r_div   <= baud_div;
      end

      if (w_brk_rel)                   r_brk_rel <= 1'b1;
      else if (w_state_nx != ST_BREAK) r_brk_rel <= 1'b0;

      r_tx   <= w_line;
      r_done <= w_done;
    end
  end

  assign tx      = r_tx;
  assign tx_done = r_done;
  assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DIV_W = 16;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int NCAP  = 256;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [DIV_W-1:0] baud_div = '0;
  logic [1:0]       data_bit_num = 2'b11;
  logic             stop_bit_num = 1'b0;
  logic             parity_en = 1'b0;
  logic             parity_type = 1'b1;
  logic             tx_en = 1'b0;
  logic             break_req = 1'b0;
  logic             wr_valid = 1'b0;
  logic [7:0]       wr_data = '0;
  logic             wr_ready;
  logic [LW-1:0]    fifo_level;
  logic             tx;
  logic             busy;
  logic             tx_done;

  int checks   = 0;
  int failures = 0;

  logic          cap_tx   [NCAP];
  logic          cap_busy [NCAP];
  logic          cap_done [NCAP];
  logic          cap_rdy  [NCAP];
  logic [LW-1:0] cap_lvl  [NCAP];

  uart_tx_fifo #(.DIV_W(DIV_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .baud_div     (baud_div),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .tx_en        (tx_en),
    .break_req    (break_req),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .fifo_level   (fifo_level),
    .tx           (tx),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int s);
    cap_tx[s]   = tx;
    cap_busy[s] = busy;
    cap_done[s] = tx_done;
    cap_rdy[s]  = wr_ready;
    cap_lvl[s]  = fifo_level;
  endtask

  task automatic capture(input int n);
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      sample(s);
    end
  endtask

  // Called at a negedge; the write is accepted on the following posedge
  task automatic write1(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // sel: 0 = tx, 1 = busy, 2 = tx_done; counts ones over [a, b]
  function automatic int cnt(input int sel, input int a, input int b);
    int n;
    n = 0;
    for (int s = a; s <= b; s++) begin
      case (sel)
        0:       n += int'(cap_tx[s]);
        1:       n += int'(cap_busy[s]);
        default: n += int'(cap_done[s]);
      endcase
    end
    return n;
  endfunction

  // bits[i] is the expected line level of bit i (bit 0 = start bit)
  task automatic chk_frame(input string tag, input int base, input int nb,
                           input logic [15:0] bits, input int per);
    logic [7:0] o;
    logic [7:0] e;
    for (int i = 0; i < nb; i++) begin
      o = '0;
      e = '0;
      for (int j = 0; j < per; j++) begin
        o[j] = cap_tx[base + i*per + j];
        e[j] = bits[i];
      end
      chk($sformatf("%s_bit%0d", tag, i), {24'd0, o}, {24'd0, e});
    end
  endtask

  int acc;
  logic [4:0] fch;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_level", fifo_level, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // ---------------- 0xA5, div 3, 8N1 ----------------
    baud_div = 16'd3; data_bit_num = 2'b11; stop_bit_num = 1'b0;
    parity_en = 1'b0; tx_en = 1'b1;
    write1(8'hA5);
    capture(60);
    chk("t1_latency_tx", cap_tx[0], 1'b1);
    chk("t1_busy_rise", cap_busy[0], 1'b1);
    chk_frame("t1", 1, 10, {1'b1, 8'hA5, 1'b0}, 4);
    chk("t1_busy_cycles", cnt(1, 0, 59), 40);
    chk("t1_done_count", cnt(2, 0, 59), 1);
    chk("t1_done_pos", {cap_done[40], cap_busy[40]}, 2'b10);

    // ---------------- 0x13, 5E2, div 0 (upper bits ignored) ----------------
    baud_div = 16'd0; data_bit_num = 2'b00; stop_bit_num = 1'b1;
    parity_en = 1'b1; parity_type = 1'b1;
    write1(8'hF3);
    capture(20);
    chk_frame("t2e", 1, 9, {1'b1, 1'b1, 1'b1, 5'h13, 1'b0}, 1);
    chk("t2e_busy_cycles", cnt(1, 0, 19), 9);
    chk("t2e_done_count", cnt(2, 0, 19), 1);

    parity_type = 1'b0;
    write1(8'h13);
    capture(20);
    chk_frame("t2o", 1, 9, {1'b1, 1'b1, 1'b0, 5'h13, 1'b0}, 1);

    // ---------------- burst fill with tx_en low ----------------
    baud_div = 16'd0; data_bit_num = 2'b00; stop_bit_num = 1'b0;
    parity_en = 1'b0; tx_en = 1'b0;
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      if (wr_ready) acc++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("t3_accepts", acc, 16);
    chk("t3_level_full", fifo_level, 16);
    chk("t3_wr_ready_full", wr_ready, 1'b0);
    tx_en = 1'b1;
    capture(130);
    chk("t3_ready_after_pop", cap_rdy[0], 1'b1);
    chk("t3_level_after_pop", cap_lvl[0], 15);
    chk("t3_busy_cycles", cnt(1, 0, 111), 112);
    chk("t3_busy_end", cap_busy[112], 1'b0);
    chk("t3_done_count", cnt(2, 0, 129), 16);
    chk("t3_b2b_gap", {cap_done[7], cap_busy[7]}, 2'b11);
    for (int f = 0; f < 16; f += 5) begin
      fch = 5'(f);
      chk_frame($sformatf("t3_f%0d", f), 1 + 7*f, 7, {1'b1, fch, 1'b0}, 1);
    end

    // ---------------- break during DATA ----------------
    @(negedge clk);
    baud_div = 16'd3; data_bit_num = 2'b11; stop_bit_num = 1'b0;
    write1(8'hA5);
    for (int s = 0; s < 90; s++) begin
      @(negedge clk);
      sample(s);
      if (s == 5)  break_req = 1'b1;
      if (s == 70) break_req = 1'b0;
    end
    chk_frame("t4", 1, 10, {1'b1, 8'hA5, 1'b0}, 4);
    chk("t4_frame_end", {cap_done[40], cap_busy[40]}, 2'b10);
    chk("t4_break_busy", cap_busy[41], 1'b1);
    chk("t4_pre_break_tx", cap_tx[41], 1'b1);
    chk("t4_break_low", cnt(0, 42, 71), 0);
    chk("t4_mark_tx", cap_tx[72], 1'b1);
    chk("t4_mark_busy", cnt(1, 71, 74), 4);
    chk("t4_idle", cap_busy[75], 1'b0);

    // ---------------- async reset mid-DATA ----------------
    write1(8'hA5);
    write1(8'h3C);
    repeat (10) @(negedge clk);
    chk("t5_pre_tx", tx, 1'b0);
    chk("t5_pre_level", fifo_level, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rst_tx", tx, 1'b1);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_level", fifo_level, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    write1(8'h5A);
    capture(60);
    chk_frame("t5", 1, 10, {1'b1, 8'h5A, 1'b0}, 4);
    chk("t5_busy_cycles", cnt(1, 0, 59), 40);

    // ---------------- baud change mid-frame ----------------
    baud_div = 16'd3;
    write1(8'hA5);
    write1(8'h0F);
    chk("t6_push_pop_level", fifo_level, 1);
    for (int s = 0; s < 130; s++) begin
      @(negedge clk);
      sample(s);
      if (s == 10) baud_div = 16'd7;
    end
    chk_frame("t6a", 0, 10, {1'b1, 8'hA5, 1'b0}, 4);
    chk("t6_b2b", {cap_done[39], cap_busy[39]}, 2'b11);
    chk_frame("t6b", 40, 10, {1'b1, 8'h0F, 1'b0}, 8);
    chk("t6_busy_cycles", cnt(1, 0, 129), 119);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
